// File: rtl/branch_resolve_unit.sv
// In-order branch resolution: queues fetch predictions, checks them against execute, emits next PC and flush.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int WordSize = 32,
  parameter int Depth    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic                pred_taken,
  input  logic [WordSize-1:0] pred_pc,
  input  logic [WordSize-1:0] pred_addr,
  output logic                pred_ready,
  input  logic                res_valid,
  input  logic                act_taken,
  input  logic [WordSize-1:0] act_addr,
  output logic                flush,
  output logic                npc_valid,
  output logic [WordSize-1:0] npc,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int PtrW = $clog2(Depth);

  typedef enum logic [1:0] {RESTART, RUN, FLUSH} state_t;

  typedef struct packed {
    logic                taken;
    logic [WordSize-1:0] pc;
    logic [WordSize-1:0] addr;
  } entry_t;

  state_t              state_q, state_d;
  entry_t              fifo_q [Depth];
  entry_t              fifo_d [Depth];
  logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
  logic                flush_q, flush_d;
  logic                npc_valid_q, npc_valid_d;
  logic [WordSize-1:0] npc_q, npc_d;

  entry_t              head;
  logic                empty;
  logic                full;
  logic                resolve;
  logic                mispredict;
  logic [WordSize-1:0] head_seq;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[PtrW] != wr_ptr_q[PtrW]) &&
                 (rd_ptr_q[PtrW-1:0] == wr_ptr_q[PtrW-1:0]);
  assign head  = fifo_q[rd_ptr_q[PtrW-1:0]];

  assign pred_ready = (state_q == RUN) && !full;
  assign resolve    = (state_q == RUN) && res_valid && !empty;
  assign mispredict = resolve && ((act_taken != head.taken) ||
                      (act_taken && head.taken && (act_addr != head.addr)));
  assign head_seq   = head.pc + WordSize'(4);

  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    flush_d     = 1'b0;
    npc_valid_d = 1'b0;
    npc_d       = npc_q;

    case (state_q)
      RESTART: state_d = RUN;
      RUN:     if (mispredict) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RESTART;
    endcase

    // A mispredict squashes everything younger, including this cycle's enqueue.
    if (pred_valid && pred_ready && !mispredict) begin
      fifo_d[wr_ptr_q[PtrW-1:0]] = '{taken: pred_taken, pc: pred_pc, addr: pred_addr};
      wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
    end

    if (resolve) begin
      npc_valid_d = 1'b1;
      if (mispredict) begin
        flush_d  = 1'b1;
        npc_d    = act_taken ? act_addr : head_seq;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end else begin
        npc_d    = head.taken ? head.addr : head_seq;
        rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESTART;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      flush_q     <= 1'b0;
      npc_valid_q <= 1'b0;
      npc_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      flush_q     <= flush_d;
      npc_valid_q <= npc_valid_d;
      npc_q       <= npc_d;
    end
  end

  // Entry storage needs no reset: it is only read when the pointers say it is valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign flush     = flush_q;
  assign npc_valid = npc_valid_q;
  assign npc       = npc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && (branch_count_q != 32'hFFFF_FFFF))
      branch_count_d = branch_count_q + 32'd1;
    if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model queues expected resolve results.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_pc, pred_addr;
  logic        pred_ready;
  logic        res_valid, act_taken;
  logic [31:0] act_addr;
  logic        flush, npc_valid;
  logic [31:0] npc;
  logic [31:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WordSize(32), .Depth(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_pc          (pred_pc),
    .pred_addr        (pred_addr),
    .pred_ready       (pred_ready),
    .res_valid        (res_valid),
    .act_taken        (act_taken),
    .act_addr         (act_addr),
    .flush            (flush),
    .npc_valid        (npc_valid),
    .npc              (npc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct {
    logic        t;
    logic [31:0] pc;
    logic [31:0] addr;
  } ent_t;

  typedef struct {
    logic        fl;
    logic [31:0] npc;
  } res_t;

  ent_t        mq[$];
  res_t        eq[$];
  int          mstate = 0;  // 0 restart, 1 run, 2 flush
  logic [31:0] mnpc = '0;
  logic [31:0] mbc = '0;
  logic [31:0] mmc = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check outputs of the previous edge, then advance the model.
  task automatic cyc(input logic r, input logic pv, input logic pt, input logic [31:0] ppc,
                     input logic [31:0] paddr, input logic rv, input logic at,
                     input logic [31:0] aa);
    logic mready, res, mis;
    ent_t h;
    res_t e;
    rst = r; pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_addr = paddr;
    res_valid = rv; act_taken = at; act_addr = aa;
    @(negedge clk);
    if (eq.size() > 0) begin
      e = eq.pop_front();
      chk("npc_valid", npc_valid, 1);
      chk("flush", flush, e.fl);
      mnpc = e.npc;
    end else begin
      chk("npc_valid_idle", npc_valid, 0);
      chk("flush_idle", flush, 0);
    end
    chk("npc", npc, mnpc);
    mready = (mstate == 1) && (mq.size() < 4);
    chk("pred_ready", pred_ready, mready);
    chk("branch_count", branch_count, mbc);
    chk("mispredict_count", mispredict_count, mmc);

    if (r) begin
      mstate = 0; mq.delete(); eq.delete(); mnpc = '0; mbc = '0; mmc = '0;
    end else if (mstate != 1) begin
      mstate = 1;
    end else begin
      res = rv && (mq.size() > 0);
      mis = 1'b0;
      if (res) begin
        h = mq.pop_front();
        mis = (at != h.t) || (at && h.t && (aa != h.addr));
        e.fl = mis;
        if (mis) e.npc = at ? aa : h.pc + 32'd4;
        else     e.npc = h.t ? h.addr : h.pc + 32'd4;
        eq.push_back(e);
`ifdef BRANCH_STATS_EN
        if (mbc != 32'hFFFF_FFFF) mbc++;
        if (mis && mmc != 32'hFFFF_FFFF) mmc++;
`endif
      end
      if (mis) begin
        mq.delete();
        mstate = 2;
      end else if (pv && mready) begin
        mq.push_back('{t: pt, pc: ppc, addr: paddr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic pt, input logic [31:0] ppc, input logic [31:0] paddr);
    cyc(0, 1, pt, ppc, paddr, 0, 0, 0);
  endtask

  task automatic rsv(input logic at, input logic [31:0] aa);
    cyc(0, 0, 0, 0, 0, 1, at, aa);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_addr = 0;
    res_valid = 0; act_taken = 0; act_addr = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // First cycle after reset: resolve is ignored.
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h44);
    idle();

    // Correct taken prediction.
    enq(1, 32'h100, 32'h200);
    rsv(1, 32'h200);
    idle();

    // Three entries, head mispredicted not-taken; enqueue in the same cycle is dropped.
    enq(0, 32'h100, 32'h0);
    enq(1, 32'h500, 32'h600);
    enq(0, 32'h700, 32'h0);
    cyc(0, 1, 1, 32'h800, 32'h900, 1, 1, 32'h300);
    idle();
    idle();
    // Resolve against empty FIFO is ignored.
    rsv(1, 32'h123);
    idle();

    // Fill to Depth, fifth offer refused, resolve with offer shows no bypass.
    enq(0, 32'h10, 32'h0);
    enq(1, 32'h20, 32'h30);
    enq(0, 32'h40, 32'h0);
    enq(1, 32'h50, 32'h60);
    enq(1, 32'hDEAD0, 32'hBEEF0);
    cyc(0, 1, 1, 32'hDEAD0, 32'hBEEF0, 1, 0, 32'h0);
    // Simultaneous enqueue and correct dequeue.
    cyc(0, 1, 0, 32'hFFFF_FFFC, 32'h0, 1, 1, 32'h30);
    rsv(0, 32'h0);
    rsv(1, 32'h60);
    // pc+4 wraps to zero.
    rsv(0, 32'h0);
    idle();

    // Both taken, wrong target.
    enq(1, 32'h900, 32'hA00);
    rsv(1, 32'hB00);
    idle();
    idle();
`ifdef BRANCH_STATS_EN
    chk("branch_count_directed", branch_count, 32'd8);
    chk("mispredict_count_directed", mispredict_count, 32'd2);
`else
    chk("branch_count_disabled", branch_count, 32'd0);
    chk("mispredict_count_disabled", mispredict_count, 32'd0);
`endif

    // Reset asserted in the FLUSH cycle.
    enq(0, 32'h10, 32'h0);
    rsv(1, 32'h20);
    cyc(1, 1, 1, 32'h30, 32'h40, 1, 1, 32'h50);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      logic        pv, pt, rv, at;
      logic [31:0] ppc, paddr, aa;
      pv    = ($urandom_range(0, 2) != 0);
      pt    = $urandom_range(0, 1);
      ppc   = {$urandom_range(0, 255), 2'b00};
      paddr = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80;
      if (i % 97 == 5) ppc = 32'hFFFF_FFFC;
      rv    = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        at = mq[0].t;
        aa = mq[0].addr;
      end else begin
        at = $urandom_range(0, 1);
        aa = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80;
      end
      cyc((i % 150 == 149), pv, pt, ppc, paddr, rv, at, aa);
    end
    idle();
    idle();
    chk("scoreboard_drained", 64'(eq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WordSize, default 32: width of all PC/address ports.
REQ-002 SHALL have parameter Depth, default 4: number of outstanding predicted branches; power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port pred_valid, input, 1: fetch presents a prediction.
REQ-006 SHALL have port pred_taken, input, 1: predicted direction.
REQ-007 SHALL have port pred_pc, input, WordSize: PC of the predicted branch.
REQ-008 SHALL have port pred_addr, input, WordSize: predicted target.
REQ-009 SHALL have port pred_ready, output, 1: prediction accepted this cycle when high with pred_valid.
REQ-010 SHALL have port res_valid, input, 1: execute resolves the oldest outstanding branch.
REQ-011 SHALL have port act_taken, input, 1: resolved direction.
REQ-012 SHALL have port act_addr, input, WordSize: resolved target, meaningful when act_taken=1.
REQ-013 SHALL have port flush, output, 1: one-cycle pipeline flush pulse.
REQ-014 SHALL have port npc_valid, output, 1: npc valid this cycle.
REQ-015 SHALL have port npc, output, WordSize: next PC after the resolved branch.
REQ-016 SHALL have port branch_count, output, 32: resolved branches.
REQ-017 SHALL have port mispredict_count, output, 32: mispredicted branches.

Function
REQ-018 SHALL hold predictions in an in-order FIFO of Depth entries {pred_taken, pred_pc, pred_addr}; enqueue when pred_valid && pred_ready.
REQ-019 SHALL drive pred_ready = (state==RUN) && !full; no bypass on a simultaneous dequeue when full.
REQ-020 SHALL use states RESTART, RUN, FLUSH; RESTART->RUN after one cycle; RUN->FLUSH on mispredict; FLUSH->RUN after one cycle.
REQ-021 SHALL, in RESTART and FLUSH, ignore res_valid and pred_valid; FIFO unchanged except the clear in REQ-024.
REQ-022 SHALL, in RUN with res_valid and FIFO non-empty, dequeue the head and classify it as a mispredict when act_taken!=head.taken, or when both are taken and act_addr!=head.addr.
REQ-023 SHALL register outputs one cycle after the resolve: npc_valid=1; npc = act_taken ? act_addr : head.pc+4 on a mispredict; npc = head.taken ? head.addr : head.pc+4 otherwise; flush=1 only on a mispredict.
REQ-024 SHALL, on a mispredict, discard all younger entries (FIFO emptied) and drop any enqueue in the same cycle.
REQ-025 SHALL compute pc+4 modulo 2^WordSize (0xFFFFFFFC+4 -> 0x00000000).
REQ-026 SHALL ignore res_valid when the FIFO is empty: no outputs, no count change.
REQ-027 SHALL deassert flush and npc_valid in every cycle without a qualifying resolve; npc holds its last value.
REQ-028 SHALL allow an enqueue and a non-mispredict dequeue in the same cycle with occupancy unchanged.

Reset
REQ-029 SHALL, while rst=1, set state=RESTART, FIFO empty, flush=0, npc_valid=0, npc=0, pred_ready=0, both counters 0.
REQ-030 SHALL let reset mid-operation, including during FLUSH, override all other activity in that cycle.

Configuration
REQ-031 SHALL compile the counters only when macro BRANCH_STATS_EN is defined: branch_count increments per qualifying resolve and mispredict_count per mispredict, both saturating at 0xFFFFFFFF.
REQ-032 SHALL, without BRANCH_STATS_EN, tie branch_count and mispredict_count to 0 and build no counter logic.

Verification
REQ-033 SHALL cover: reset, then res_valid=1 in the first cycle after reset -> ignored, flush=0, npc_valid=0.
REQ-034 SHALL cover: enqueue {taken=1, pc=0x100, addr=0x200}, resolve act_taken=1, act_addr=0x200 -> next cycle npc_valid=1, npc=0x200, flush=0.
REQ-035 SHALL cover: enqueue 3 entries, head {taken=0, pc=0x100}, resolve act_taken=1, act_addr=0x300 -> flush=1, npc=0x300, FIFO empty, pred_ready=0 for one cycle.
REQ-036 SHALL cover: enqueue 4 entries (Depth=4) -> pred_ready=0; a 5th pred_valid is not accepted; one resolve reopens pred_ready.
REQ-037 SHALL cover: head {taken=0, pc=0xFFFFFFFC}, resolve act_taken=0 -> npc=0x00000000.
REQ-038 SHALL cover: with BRANCH_STATS_EN, 5 resolves including 2 mispredicts -> branch_count=5, mispredict_count=2; without the macro, both counters stay 0.
